// File: rtl/rest_divider_pkg.sv
// Shared definitions for the restoring fixed-point divider:
// FSM state encoding and default operand/fraction widths.
package rest_divider_pkg;

    localparam int NI_DEF = 8;
    localparam int NF_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rest_div_step.sv
// One combinational restoring shift-subtract step.
// Ports: i_rem partial remainder in, i_bit next dividend bit,
//        i_dvs divisor, o_q quotient bit, o_rem partial remainder out.
module rest_div_step #(
    parameter int NI = 8
) (
    input  logic [NI-1:0] i_rem,
    input  logic          i_bit,
    input  logic [NI-1:0] i_dvs,
    output logic          o_q,
    output logic [NI-1:0] o_rem
);

    logic [NI:0] w_shift;

    assign w_shift = {i_rem, i_bit};

    // Compare on NI+1 bits; the kept difference is below the
    // divisor, so its low NI bits are exact.
    assign o_q   = (w_shift >= {1'b0, i_dvs});
    assign o_rem = o_q ? (w_shift[NI-1:0] - i_dvs)
                       : w_shift[NI-1:0];

endmodule

// File: rtl/rest_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Ports: clk, reset (async, active-low), start, dividend, divisor
//        in; Q (NI.NF fixed point), remainder, ready out.
module rest_divider
    import rest_divider_pkg::*;
#(
    parameter int NI = NI_DEF,
    parameter int NF = NF_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NI-1:0]    dividend,
    input  logic [NI-1:0]    divisor,
    output logic [NF+NI-1:0] Q,
    output logic [NI-1:0]    remainder,
    output logic             ready
);

    localparam int NT = NI + NF;
    localparam int CW = $clog2(NT + 1);

    state_t          r_state;
    state_t          w_next;
    logic [NT-1:0]   r_dvd;
    logic [NI-1:0]   r_dvs;
    logic [NI-1:0]   r_rem;
    logic [NT-1:0]   r_q;
    logic [CW-1:0]   r_cnt;
    logic            r_ready;

    logic            w_accept;
    logic            w_last;
    logic            w_qbit;
    logic [NI-1:0]   w_rem;

    // start is only honoured outside BUSY
    assign w_accept = start && (r_state != BUSY);
    assign w_last   = (r_cnt == CW'(NT - 1));

    rest_div_step #(
        .NI (NI)
    ) u_step (
        .i_rem (r_rem),
        .i_bit (r_dvd[NT-1]),
        .i_dvs (r_dvs),
        .o_q   (w_qbit),
        .o_rem (w_rem)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start)  w_next = BUSY;
            BUSY:    if (w_last) w_next = DONE;
            DONE:    if (start)  w_next = BUSY;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                // Dividend is pre-scaled so fraction bits shift in as zeros
                r_dvd   <= NT'(dividend) << NF;
                r_dvs   <= divisor;
                r_rem   <= '0;
                r_q     <= '0;
                r_cnt   <= '0;
                r_ready <= 1'b0;
            end else if (r_state == BUSY) begin
                r_dvd <= {r_dvd[NT-2:0], 1'b0};
                r_q   <= {r_q[NT-2:0], w_qbit};
                r_cnt <= r_cnt + CW'(1);
                // A zero divisor leaves junk in the remainder; clear it
                if (w_last && (r_dvs == '0)) begin
                    r_rem <= '0;
                end else begin
                    r_rem <= w_rem;
                end
                if (w_last) begin
                    r_ready <= 1'b1;
                end
            end
        end
    end

    assign Q         = r_q;
    assign remainder = r_rem;
    assign ready     = r_ready;

endmodule

// File: tb/tb_rest_divider.sv
// Directed self-checking bench for rest_divider (NI=8, NF=8).
// Ports: none; drives clk/reset/start/operands, checks Q/remainder/ready.
module tb_rest_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  dividend;
    logic [7:0]  divisor;
    logic [15:0] Q;
    logic [7:0]  remainder;
    logic        ready;

    int total = 0;
    int bad   = 0;

    rest_divider #(
        .NI (8),
        .NF (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .Q         (Q),
        .remainder (remainder),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One division; operands are scrambled after acceptance and an
    // optional start pulse is raised while BUSY (pulse_at = 0: none).
    task automatic do_div(input string tag, input logic [7:0] dd,
                          input logic [7:0] ds, input logic [15:0] eq,
                          input logic [7:0] er, input int pulse_at);
        @(negedge clk);
        dividend = dd;
        divisor  = ds;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = ~dd;
        divisor  = ds + 8'h5A;
        chk({tag, "_rdy_clr"}, {31'd0, ready}, 32'd0);
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            start = (i == pulse_at);
            if (pulse_at != 0 && i == pulse_at) begin
                dividend = 8'h64;
                divisor  = 8'h07;
            end
            if (i == 15) begin
                chk({tag, "_rdy_early"}, {31'd0, ready}, 32'd0);
            end
        end
        start = 1'b0;
        chk({tag, "_rdy"}, {31'd0, ready}, 32'd1);
        chk({tag, "_q"}, {16'd0, Q}, {16'd0, eq});
        chk({tag, "_rem"}, {24'd0, remainder}, {24'd0, er});
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        dividend = 8'h00;
        divisor  = 8'h00;
        #2;
        chk("rst_q", {16'd0, Q}, 32'd0);
        chk("rst_rem", {24'd0, remainder}, 32'd0);
        chk("rst_rdy", {31'd0, ready}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        do_div("d64_07", 8'h64, 8'h07, 16'h0E49, 8'h01, 0);

        // DONE holds results until the next accepted start
        repeat (3) @(posedge clk);
        #1;
        chk("hold_rdy", {31'd0, ready}, 32'd1);
        chk("hold_q", {16'd0, Q}, 32'h0E49);
        chk("hold_rem", {24'd0, remainder}, 32'h01);

        do_div("dff_01", 8'hFF, 8'h01, 16'hFF00, 8'h00, 0);
        do_div("d01_ff", 8'h01, 8'hFF, 16'h0001, 8'h01, 0);
        do_div("d80_03", 8'h80, 8'h03, 16'h2AAA, 8'h02, 0);
        do_div("d00_05", 8'h00, 8'h05, 16'h0000, 8'h00, 0);
        do_div("d42_00", 8'h42, 8'h00, 16'hFFFF, 8'h00, 0);
        do_div("busy_pulse", 8'h80, 8'h03, 16'h2AAA, 8'h02, 5);

        // Reset in the middle of an operation
        @(negedge clk);
        dividend = 8'h64;
        divisor  = 8'h07;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_q", {16'd0, Q}, 32'h000E);
        chk("mid_rem", {24'd0, remainder}, 32'h02);
        reset = 1'b0;
        #1;
        chk("abort_q", {16'd0, Q}, 32'd0);
        chk("abort_rem", {24'd0, remainder}, 32'd0);
        chk("abort_rdy", {31'd0, ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        do_div("after_rst", 8'h64, 8'h07, 16'h0E49, 8'h01, 0);

        // Reset while DONE clears ready asynchronously
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("done_rst_rdy", {31'd0, ready}, 32'd0);
        chk("done_rst_q", {16'd0, Q}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        do_div("final", 8'hC8, 8'h0A, 16'h1400, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rest_divider.md
REST_DIVIDER -- requirements
Module: rest_divider

Interface
REQ-001 The parameter NI SHALL default to 8 and set the integer width of the dividend, divisor and remainder.
REQ-002 The parameter NF SHALL default to 8 and set the number of fractional quotient bits.
REQ-003 Port clk SHALL be an input, 1 bit wide, and be the single rising-edge clock.
REQ-004 Port reset SHALL be an input, 1 bit wide, asynchronous and active-low.
REQ-005 Port start SHALL be an input, 1 bit wide, and request a division.
REQ-006 Port dividend SHALL be an input, NI bits wide, holding the unsigned dividend.
REQ-007 Port divisor SHALL be an input, NI bits wide, holding the unsigned divisor.
REQ-008 Port Q SHALL be an output, NF+NI bits wide, holding the unsigned quotient in fixed point: upper NI bits integer, lower NF bits fraction.
REQ-009 Port remainder SHALL be an output, NI bits wide, holding the final partial remainder.
REQ-010 Port ready SHALL be an output, 1 bit wide, flagging that the result is valid.

Function
REQ-011 The block SHALL compute Q = floor(dividend*2^NF / divisor) and remainder = (dividend*2^NF) mod divisor, using the restoring shift-subtract algorithm with one quotient bit per clock.
REQ-012 The state machine SHALL have three states: IDLE, BUSY and DONE. IDLE goes to BUSY on start=1, BUSY goes to DONE after NF+NI iterations, and DONE goes to BUSY on start=1.
REQ-013 The block SHALL sample start only in IDLE or DONE; start asserted while BUSY SHALL be ignored.
REQ-014 On the accepting edge E0 the block SHALL register dividend and divisor, clear the partial remainder and Q, clear ready, and zero the iteration counter.
REQ-015 At each of edges E1..E16, the partial remainder (NI+1 bits) SHALL shift left, taking in the next dividend bit (MSB first, then zeros for the fraction). It SHALL then subtract the divisor. A non-negative result SHALL be kept and shift a 1 into Q; otherwise the remainder SHALL be restored and a 0 shifted into Q.
REQ-016 ready SHALL be set at edge E16, so that it samples high at edge E0+17 (17 clocks after start is sampled).
REQ-017 In DONE, ready SHALL stay at 1 and Q and remainder SHALL hold until the next accepted start.
REQ-018 Changes on dividend or divisor after E0 SHALL NOT affect the current operation.
REQ-019 When divisor = 0, the block SHALL produce Q = all ones and remainder = 0, with the same 17-cycle latency.
REQ-020 Intermediate subtraction SHALL use NI+1 bits so no overflow occurs; the remainder output SHALL always be less than divisor (for divisor ≠ 0).

Reset
REQ-021 While reset=0, the block SHALL force IDLE, Q=0, remainder=0, ready=0, and clear the counter, immediately and without waiting for clk.
REQ-022 Reset asserted mid-operation SHALL abort the division; a new start after release SHALL begin cleanly.

Structure
REQ-023 The state encoding (IDLE/BUSY/DONE) and the default NI/NF values SHALL live in a shared package rest_divider_pkg.
REQ-024 The design SHALL be a single FSM and datapath; one optional sub-module, rest_div_step (a combinational single shift-subtract-restore step), is permitted.
REQ-025 The iteration counter SHALL be sized ceil(log2(NF+NI+1)) bits.

Verification
REQ-026 Scenario: dividend=0x64, divisor=0x07, start -> Q=0x0E49, remainder=0x01, with ready high at the 17th edge.
REQ-027 Scenario: dividend=0xFF, divisor=0x01 -> Q=0xFF00, remainder=0x00; and dividend=0x01, divisor=0xFF -> Q=0x0001, remainder=0x01.
REQ-028 Scenario: dividend=0x80, divisor=0x03 -> Q=0x2AAA, remainder=0x02; and dividend=0x00, divisor=0x05 -> Q=0x0000, remainder=0x00.
REQ-029 Scenario: divisor=0x00, dividend=0x42 -> Q=0xFFFF, remainder=0x00, ready at 17 clocks.
REQ-030 Scenario: reset=0 at iteration 8 -> Q, remainder and ready go to 0 immediately; a following division of 0x64/0x07 -> Q=0x0E49.
REQ-031 Scenario: start re-pulsed while BUSY -> ignored, result unchanged; back-to-back starts from DONE each give ready 17 clocks later.
